pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Sequences power-up and recovery of the SDRAM clock PLL, which takes a 27 MHz reference and produces 100 MHz, phase-shifted 100 MHz and 18.37 MHz outputs.
- Drives the PLL reset and qualifies its asynchronous locked flag.
- Holds the SDRAM controller and video pipeline in reset until lock has been stable for a set time.
- Re-sequences on lock loss or on request, with bounded retries.
- Runs entirely in the refclk domain, in the PLL wrapper's parent.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (1..65535).
- STABLE_CYCLES, 256: consecutive cycles of synchronized lock required before release (1..65535).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before an attempt fails (1..65535).
- HOLD_CYCLES, 64: extra cycles sdram_rst stays high after lock is qualified (1..65535).
- MAX_RETRY, 3: retries after the first failed attempt before giving up (0..15).

Ports:
- refclk, in, 1: reference clock, 27 MHz; the only clock.
- rst, in, 1: asynchronous, active-high reset.
- pll_locked, in, 1: PLL locked flag; asynchronous to refclk.
- req_relock, in, 1: single-cycle synchronous request to restart the sequence.
- pll_rst, out, 1: reset to the PLL, active-high.
- sdram_rst, out, 1: downstream reset, active-high.
- ready, out, 1: high only in RUN.
- lock_fail, out, 1: high only in FAIL.
- retry_cnt, out, 4: failed attempts in the current sequence.
- loss_cnt, out, 8: lock losses seen in RUN (see Optional Feature).

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = PLL_RST, all counters = 0, synchronizer flops = 0.
  - pll_rst = 1, sdram_rst = 1, ready = 0, lock_fail = 0, retry_cnt = 0, loss_cnt = 0.
- pll_locked passes through a 2-flop synchronizer to give locked_s; the FSM uses only locked_s.
- Timer: one 16-bit cycle counter, cleared on every state entry.
- PLL_RST:
  - pll_rst = 1, sdram_rst = 1.
  - Lasts exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0, sdram_rst = 1.
  - Timeout counter increments every cycle.
  - Stable counter increments while locked_s = 1 and clears when locked_s = 0.
  - Stable counter reaching STABLE_CYCLES -> HOLD. If this coincides with timeout, stable wins.
  - Timeout counter reaching LOCK_TIMEOUT with retry_cnt < MAX_RETRY -> retry_cnt + 1, then PLL_RST.
  - Timeout with retry_cnt = MAX_RETRY -> retry_cnt + 1 (saturating at 15), then FAIL.
- HOLD:
  - sdram_rst = 1; lasts HOLD_CYCLES cycles, then RUN.
  - locked_s = 0 during HOLD -> PLL_RST, counted as a failed attempt with the same retry/FAIL rule as timeout.
- RUN:
  - sdram_rst = 0, ready = 1.
  - locked_s = 0 -> PLL_RST, retry_cnt cleared, loss event raised.
  - sdram_rst is re-asserted on the same edge that ready falls.
- FAIL:
  - pll_rst = 1, sdram_rst = 1, lock_fail = 1.
  - Exits only on req_relock or rst.
- req_relock:
  - From any state -> PLL_RST with retry_cnt cleared; takes priority over all other transitions.
  - In PLL_RST it restarts the RST_CYCLES count.
- Nominal latency: ready rises RST_CYCLES + STABLE_CYCLES + HOLD_CYCLES cycles after rst deasserts, provided pll_locked is already high and synchronized.
- Output timing: all outputs are registered. rst asserting mid-sequence forces the reset values immediately.

Optional Feature:
- Macro: PLL_LOSS_COUNT_EN.
- Defined:
  - loss_cnt increments by 1 on each RUN-state lock loss.
  - Saturates at 255.
  - Cleared only by rst; req_relock does not clear it.
- Undefined: loss_cnt is tied to 0 and the counter logic is absent.
- The port list is identical in both builds.

Test Plan:
All scenarios use RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, HOLD_CYCLES=4, MAX_RETRY=2.
1. Normal power-up: pll_locked held 1, rst released -> pll_rst falls after 4 cycles; sdram_rst falls and ready rises 16 cycles after rst deassert; retry_cnt = 0.
2. Lock never asserts: pll_locked = 0 -> three attempts of 36 cycles each; lock_fail = 1 at cycle 108; retry_cnt = 2 then 3; sdram_rst stays 1 throughout.
3. Lock glitch during qualification: pll_locked drops for 1 cycle after 5 stable cycles -> stable count restarts; ready rises 8 + 4 cycles after lock returns.
4. Lock loss in RUN: pll_locked drops for 3 cycles -> ready = 0 and sdram_rst = 1 within 3 cycles of the drop (synchronizer + FSM); full re-sequence follows; loss_cnt = 1 with PLL_LOSS_COUNT_EN, 0 without.
5. Recovery from FAIL: pulse req_relock -> retry_cnt = 0, lock_fail = 0, pll_rst high for 4 cycles; with pll_locked = 1, ready rises 16 cycles after the pulse.
6. Reset mid-HOLD: assert rst -> pll_rst = 1, sdram_rst = 1, ready = 0 asynchronously; full sequence restarts on release.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the SDRAM clock PLL, running in the refclk domain.
// Define PLL_LOSS_COUNT_EN to count RUN-state lock losses on loss_cnt (otherwise tied to 0).
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_relock,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       ready,
    output logic       lock_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // state     | meaning
    // PLL_RST   | PLL held in reset for RST_CYCLES
    // WAIT_LOCK | waiting for STABLE_CYCLES of continuous lock, or timeout
    // HOLD      | lock qualified, downstream reset held HOLD_CYCLES longer
    // RUN       | downstream released, ready high
    // FAIL      | retries exhausted, waiting for req_relock
    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        HOLD,
        RUN,
        FAIL
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] stable_q, stable_d;
    logic [3:0]  retry_q, retry_d;
    logic [3:0]  retry_inc;
    logic        sync1_q, locked_s_q;
    logic        attempt_fail;
    logic        pll_rst_q, pll_rst_d;
    logic        sdram_rst_q, sdram_rst_d;
    logic        ready_q, ready_d;
    logic        lock_fail_q, lock_fail_d;

    assign retry_inc = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 16'd1;
        stable_d     = 16'd0;
        retry_d      = retry_q;
        attempt_fail = 1'b0;

        if (req_relock) begin
            state_d = PLL_RST;
            timer_d = 16'd0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = 16'd0;
                    end
                end
                WAIT_LOCK: begin
                    stable_d = locked_s_q ? stable_q + 16'd1 : 16'd0;
                    // Qualification takes precedence over a timeout on the same cycle.
                    if (locked_s_q && (stable_q == STABLE_LAST)) begin
                        state_d  = HOLD;
                        timer_d  = 16'd0;
                        stable_d = 16'd0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        attempt_fail = 1'b1;
                    end
                end
                HOLD: begin
                    if (!locked_s_q) begin
                        attempt_fail = 1'b1;
                    end else if (timer_q == HOLD_LAST) begin
                        state_d = RUN;
                        timer_d = 16'd0;
                    end
                end
                RUN: begin
                    timer_d = timer_q;
                    if (!locked_s_q) begin
                        state_d = PLL_RST;
                        timer_d = 16'd0;
                        retry_d = 4'd0;
                    end
                end
                FAIL: begin
                    timer_d = timer_q;
                end
                default: begin
                    state_d = PLL_RST;
                    timer_d = 16'd0;
                end
            endcase

            if (attempt_fail) begin
                retry_d  = retry_inc;
                state_d  = (retry_q >= RETRY_MAX) ? FAIL : PLL_RST;
                timer_d  = 16'd0;
                stable_d = 16'd0;
            end
        end

        pll_rst_d   = (state_d == PLL_RST) || (state_d == FAIL);
        sdram_rst_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
        lock_fail_d = (state_d == FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            timer_q     <= 16'd0;
            stable_q    <= 16'd0;
            retry_q     <= 4'd0;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            pll_rst_q   <= 1'b1;
            sdram_rst_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            sync1_q     <= pll_locked;
            locked_s_q  <= sync1_q;
            pll_rst_q   <= pll_rst_d;
            sdram_rst_q <= sdram_rst_d;
            ready_q     <= ready_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sdram_rst = sdram_rst_q;
    assign ready     = ready_q;
    assign lock_fail = lock_fail_q;
    assign retry_cnt = retry_q;

`ifdef PLL_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_q, loss_d;

    // A loss only counts when the RUN exit is actually taken, not pre-empted by req_relock.
    assign loss_evt = (state_q == RUN) && !locked_s_q && !req_relock;

    always_comb begin
        loss_d = loss_q;
        if (loss_evt && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: constant vector table, corner sequences, and random
// stimulus checked every cycle against a phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RST_C    = 4;
    localparam int STABLE_C = 8;
    localparam int TMO_C    = 32;
    localparam int HOLD_C   = 4;
    localparam int MAXR     = 2;

`ifdef PLL_LOSS_COUNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       req_relock;
    logic       pll_rst;
    logic       sdram_rst;
    logic       ready;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int   m_phase, m_age, m_run, m_retry, m_loss;
    logic m_s1, m_s2;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .STABLE_CYCLES(STABLE_C),
        .LOCK_TIMEOUT (TMO_C),
        .HOLD_CYCLES  (HOLD_C),
        .MAX_RETRY    (MAXR)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .req_relock(req_relock),
        .pll_rst   (pll_rst),
        .sdram_rst (sdram_rst),
        .ready     (ready),
        .lock_fail (lock_fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 refclk = ~refclk;

    function automatic logic [15:0] expv(input bit pr, input bit sd, input bit rd, input bit lf,
                                         input int rc, input int lc);
        return {pr, sd, rd, lf, 4'(rc), 8'(lc)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {pll_rst, sdram_rst, ready, lock_fail, retry_cnt, loss_cnt};
    endfunction

    function automatic logic [15:0] model_vec();
        return expv(m_phase == PH_RST || m_phase == PH_FAIL, m_phase != PH_RUN,
                    m_phase == PH_RUN, m_phase == PH_FAIL, m_retry, LOSS_EN != 0 ? m_loss : 0);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {pll_rst,sdram_rst,ready,lock_fail,retry,loss}=%h required %h",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_RST;
        m_age   = 0;
        m_run   = 0;
        m_retry = 0;
        m_loss  = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_age   = 0;
        m_run   = 0;
    endtask

    task automatic attempt_failed();
        if (m_retry >= MAXR) begin
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            enter(PH_FAIL);
        end else begin
            m_retry = m_retry + 1;
            enter(PH_RST);
        end
    endtask

    // One refclk edge of the reference: m_age counts cycles spent in the current phase.
    task automatic model_step();
        logic ls;
        if (rst) begin
            model_reset();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        if (req_relock) begin
            m_retry = 0;
            enter(PH_RST);
            return;
        end
        m_age++;
        case (m_phase)
            PH_RST:  if (m_age == RST_C) enter(PH_WAIT);
            PH_WAIT: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == STABLE_C) enter(PH_HOLD);
                else if (m_age == TMO_C) attempt_failed();
            end
            PH_HOLD: begin
                if (!ls) attempt_failed();
                else if (m_age == HOLD_C) enter(PH_RUN);
            end
            PH_RUN: begin
                if (!ls) begin
                    m_retry = 0;
                    if (m_loss < 255) m_loss++;
                    enter(PH_RST);
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge refclk);
            model_step();
            check("model", dut_vec(), model_vec());
        end
    endtask

    typedef struct {
        logic        rst_i;
        logic        lk;
        logic        req;
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int L1;
        int span;
        L1 = (LOSS_EN != 0) ? 1 : 0;

        // Power-up, loss in RUN, three timed-out attempts, FAIL, recovery by req_relock.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2,  expv(1, 1, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3,  expv(1, 1, 0, 0, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1,  expv(0, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 11, expv(0, 1, 0, 0, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1,  expv(0, 0, 1, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2,  expv(0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1,  expv(1, 1, 0, 0, 0, L1)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 35, expv(0, 1, 0, 0, 0, L1)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1,  expv(1, 1, 0, 0, 1, L1)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 36, expv(1, 1, 0, 0, 2, L1)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 35, expv(0, 1, 0, 0, 2, L1)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1,  expv(1, 1, 0, 1, 3, L1)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 20, expv(1, 1, 0, 1, 3, L1)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 10, expv(1, 1, 0, 1, 3, L1)};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1,  expv(1, 1, 0, 0, 0, L1)};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 3,  expv(1, 1, 0, 0, 0, L1)};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1,  expv(0, 1, 0, 0, 0, L1)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 12, expv(0, 0, 1, 0, 0, L1)};

        rst        = 1'b1;
        pll_locked = 1'b1;
        req_relock = 1'b0;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            rst        = tbl[i].rst_i;
            pll_locked = tbl[i].lk;
            req_relock = tbl[i].req;
            if (rst) model_reset();
            cycle(tbl[i].n);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Async reset out of RUN, then a one-cycle lock glitch during qualification.
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_run", dut_vec(), expv(1, 1, 0, 0, 0, 0));
        cycle(2);
        rst        = 1'b0;
        pll_locked = 1'b1;
        cycle(9);
        pll_locked = 1'b0;
        cycle(1);
        pll_locked = 1'b1;
        cycle(13);
        check("glitch_hold", dut_vec(), expv(0, 1, 0, 0, 0, 0));
        cycle(1);
        check("glitch_run", dut_vec(), expv(0, 0, 1, 0, 0, 0));

        // Reset asserted while in HOLD.
        rst = 1'b1;
        model_reset();
        cycle(2);
        rst = 1'b0;
        cycle(14);
        check("in_hold", dut_vec(), expv(0, 1, 0, 0, 0, 0));
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_hold", dut_vec(), expv(1, 1, 0, 0, 0, 0));
        cycle(2);
        rst = 1'b0;
        cycle(15);
        check("restart_pre_run", dut_vec(), expv(0, 1, 0, 0, 0, 0));
        cycle(1);
        check("restart_run", dut_vec(), expv(0, 0, 1, 0, 0, 0));

        // Lock loss seen on the last HOLD cycle beats the move to RUN.
        rst = 1'b1;
        model_reset();
        cycle(2);
        rst = 1'b0;
        cycle(13);
        pll_locked = 1'b0;
        cycle(3);
        check("hold_loss", dut_vec(), expv(1, 1, 0, 0, 1, 0));

        // req_relock inside PLL_RST restarts the reset count and clears retry_cnt.
        pll_locked = 1'b1;
        cycle(2);
        req_relock = 1'b1;
        cycle(1);
        req_relock = 1'b0;
        cycle(3);
        check("relock_restart_hold", dut_vec(), expv(1, 1, 0, 0, 0, 0));
        cycle(1);
        check("relock_restart_rel", dut_vec(), expv(0, 1, 0, 0, 0, 0));

        // Random phase: lock flip rate varies per block to reach RUN, timeouts and FAIL.
        for (int blk = 0; blk < 8; blk++) begin
            case ($urandom_range(0, 2))
                0:       span = 8;
                1:       span = 40;
                default: span = 160;
            endcase
            for (int c = 0; c < 400; c++) begin
                if (rst) rst = 1'b0;
                if ($urandom_range(0, span - 1) == 0) pll_locked = ~pll_locked;
                req_relock = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 799) == 0) begin
                    rst = 1'b1;
                    model_reset();
                end
                cycle(1);
            end
        end
        rst        = 1'b0;
        req_relock = 1'b0;
        cycle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
